car_mode_ctrl: RTL and testbench

Top-level driving controller for the car simulator. It sequences power-up and power-down, and registers the car state (`state`, `moving_state`, `power`) that the driving-mode blocks read. It arbitrates which mode block (manual, semi-auto, auto) may write the next state, and keeps a moving-time mileage counter. The manual, semi-auto and auto blocks compute next-state combinationally; this block is the only place the car state is stored.

---
 rtl/car_mode_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_car_mode_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/car_mode_ctrl.sv
// Car driving controller: power sequencing FSM, registered car state,
// mode arbitration between manual/semi-auto/auto requesters, mileage counter.
module car_mode_ctrl #(
   parameter int unsigned HOLD_MS = 1000,
   parameter int unsigned IDLE_MS = 10000,
   parameter int unsigned MILE_MS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_ms,
   input  logic        power_on,
   input  logic        power_off,
   input  logic [1:0]  mode_sel,
   input  logic [1:0]  man_state,
   input  logic [3:0]  man_moving,
   input  logic        man_power,
   input  logic [1:0]  semi_state,
   input  logic [3:0]  semi_moving,
   input  logic [1:0]  auto_state,
   input  logic [3:0]  auto_moving,
   output logic        power,
   output logic [1:0]  state,
   output logic [3:0]  moving_state,
   output logic [1:0]  mode,
   output logic [15:0] mileage
);

   localparam int unsigned HOLD_W = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
   localparam int unsigned IDLE_W = (IDLE_MS > 1) ? $clog2(IDLE_MS) : 1;
   localparam int unsigned MILE_W = (MILE_MS > 1) ? $clog2(MILE_MS) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MS - 1);
   localparam logic [MILE_W-1:0] MILE_LAST = MILE_W'(MILE_MS - 1);

   localparam logic [1:0] ST_NSTART = 2'b00;
   localparam logic [1:0] ST_MOVING = 2'b10;
   localparam logic [1:0] MD_MAN    = 2'b00;
   localparam logic [1:0] MD_SEMI   = 2'b01;
   localparam logic [1:0] MD_AUTO   = 2'b10;

   typedef enum logic [1:0] {
      P_OFF    = 2'b00,
      P_ARMING = 2'b01,
      P_ON     = 2'b10
   } pwr_e;

   pwr_e              r_fsm,   w_fsm_nxt;
   logic [HOLD_W-1:0] r_hold,  w_hold_nxt;
   logic [IDLE_W-1:0] r_idle,  w_idle_nxt;
   logic [MILE_W-1:0] r_sub,   w_sub_nxt;
   logic              r_power, w_power_nxt;
   logic [1:0]        r_state, w_state_nxt;
   logic [3:0]        r_mov,   w_mov_nxt;
   logic [1:0]        r_mode,  w_mode_nxt;
   logic [15:0]       r_mil,   w_mil_nxt;

   logic [1:0]        w_req_state;
   logic [3:0]        w_req_mov;
   logic              w_nstart_on;
   logic              w_idle_to;

   // Requester selected by the granted mode
   always_comb begin
      w_req_state = man_state;
      w_req_mov   = man_moving;
      case (r_mode)
         MD_SEMI: begin
            w_req_state = semi_state;
            w_req_mov   = semi_moving;
         end
         MD_AUTO: begin
            w_req_state = auto_state;
            w_req_mov   = auto_moving;
         end
         default: begin
            w_req_state = man_state;
            w_req_mov   = man_moving;
         end
      endcase
   end

   assign w_nstart_on = (r_fsm == P_ON) && (r_state == ST_NSTART);
   assign w_idle_to   = w_nstart_on && tick_ms && (r_idle == IDLE_LAST);

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_hold_nxt  = r_hold;
      w_idle_nxt  = r_idle;
      w_sub_nxt   = r_sub;
      w_power_nxt = r_power;
      w_state_nxt = r_state;
      w_mov_nxt   = r_mov;
      w_mode_nxt  = r_mode;
      w_mil_nxt   = r_mil;

      case (r_fsm)
         P_OFF: begin
            if (power_on && !power_off) begin
               w_fsm_nxt  = P_ARMING;
               w_hold_nxt = '0;
            end
         end
         P_ARMING: begin
            if (power_off || !power_on) begin
               w_fsm_nxt  = P_OFF;
               w_hold_nxt = '0;
            end else if (tick_ms) begin
               if (r_hold == HOLD_LAST) begin
                  w_fsm_nxt  = P_ON;
                  w_hold_nxt = '0;
               end else begin
                  w_hold_nxt = r_hold + HOLD_W'(1);
               end
            end
         end
         P_ON: begin
            if (power_off || ((r_mode == MD_MAN) && !man_power) || w_idle_to) begin
               w_fsm_nxt = P_OFF;
            end else begin
               w_state_nxt = w_req_state;
               w_mov_nxt   = w_req_mov;
            end
         end
         default: w_fsm_nxt = P_OFF;
      endcase

      // Car state only exists while powered; cleared on the edge that leaves ON
      w_power_nxt = (w_fsm_nxt == P_ON);
      if (w_fsm_nxt != P_ON) begin
         w_state_nxt = ST_NSTART;
         w_mov_nxt   = 4'b0000;
      end

      if (w_nstart_on) begin
         w_mode_nxt = (mode_sel == 2'b11) ? MD_MAN : mode_sel;
      end

      if (!w_nstart_on) begin
         w_idle_nxt = '0;
      end else if (tick_ms) begin
         w_idle_nxt = w_idle_to ? '0 : r_idle + IDLE_W'(1);
      end

      // Mileage counts moving time only and survives power cycles
      if ((r_state == ST_MOVING) && tick_ms) begin
         if (r_sub == MILE_LAST) begin
            w_sub_nxt = '0;
            if (r_mil != 16'hFFFF) begin
               w_mil_nxt = r_mil + 16'd1;
            end
         end else begin
            w_sub_nxt = r_sub + MILE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fsm   <= P_OFF;
         r_hold  <= '0;
         r_idle  <= '0;
         r_sub   <= '0;
         r_power <= 1'b0;
         r_state <= ST_NSTART;
         r_mov   <= 4'b0000;
         r_mode  <= MD_MAN;
         r_mil   <= 16'd0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_hold  <= w_hold_nxt;
         r_idle  <= w_idle_nxt;
         r_sub   <= w_sub_nxt;
         r_power <= w_power_nxt;
         r_state <= w_state_nxt;
         r_mov   <= w_mov_nxt;
         r_mode  <= w_mode_nxt;
         r_mil   <= w_mil_nxt;
      end
   end

   assign power        = r_power;
   assign state        = r_state;
   assign moving_state = r_mov;
   assign mode         = r_mode;
   assign mileage      = r_mil;

endmodule

// File: tb/tb_car_mode_ctrl.sv
// Scoreboard bench for car_mode_ctrl: expected outputs are queued as stimulus is
// driven and compared after each clock edge; a second instance checks saturation.
module tb_car_mode_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, tick_ms, power_on, power_off, man_power;
   logic [1:0]  mode_sel, man_state, semi_state, auto_state;
   logic [3:0]  man_moving, semi_moving, auto_moving;
   logic        power;
   logic [1:0]  state, mode;
   logic [3:0]  moving_state;
   logic [15:0] mileage;

   logic        s_rst;
   logic        s_power;
   logic [1:0]  s_state, s_mode;
   logic [3:0]  s_moving;
   logic [15:0] s_mileage;
   logic        sat_done;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string      tag;
      logic [24:0] v;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   car_mode_ctrl #(.HOLD_MS(4), .IDLE_MS(8), .MILE_MS(3)) dut (
      .clk(clk), .rst(rst), .tick_ms(tick_ms),
      .power_on(power_on), .power_off(power_off), .mode_sel(mode_sel),
      .man_state(man_state), .man_moving(man_moving), .man_power(man_power),
      .semi_state(semi_state), .semi_moving(semi_moving),
      .auto_state(auto_state), .auto_moving(auto_moving),
      .power(power), .state(state), .moving_state(moving_state),
      .mode(mode), .mileage(mileage)
   );

   // Always moving with a tick every cycle: one mile per cycle
   car_mode_ctrl #(.HOLD_MS(1), .IDLE_MS(2), .MILE_MS(1)) sat_dut (
      .clk(clk), .rst(s_rst), .tick_ms(1'b1),
      .power_on(1'b1), .power_off(1'b0), .mode_sel(2'b00),
      .man_state(2'b10), .man_moving(4'b0001), .man_power(1'b1),
      .semi_state(2'b00), .semi_moving(4'b0000),
      .auto_state(2'b00), .auto_moving(4'b0000),
      .power(s_power), .state(s_state), .moving_state(s_moving),
      .mode(s_mode), .mileage(s_mileage)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [24:0] pk(input logic pw, input logic [1:0] st,
                                      input logic [3:0] mv, input logic [1:0] md,
                                      input logic [15:0] mil);
      return {pw, st, mv, md, mil};
   endfunction

   // Called at a negedge: drive tick for the coming edge, queue the expected result
   task automatic step_x(input logic t, input string tag, input logic [24:0] e);
      exp_t x;
      tick_ms = t;
      x.tag   = tag;
      x.v     = e;
      q.push_back(x);
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_power"},   {31'd0, power},        32'd0);
      chk({tag, "_state"},   {30'd0, state},        32'd0);
      chk({tag, "_moving"},  {28'd0, moving_state}, 32'd0);
      chk({tag, "_mode"},    {30'd0, mode},         32'd0);
      chk({tag, "_mileage"}, {16'd0, mileage},      32'd0);
   endtask

   task automatic power_up(input logic [1:0] md, input logic [15:0] mil);
      power_on = 1'b1;
      step_x(1'b0, "pu_entry", pk(1'b0, 2'b00, 4'b0000, md, mil));
      for (int i = 0; i < 3; i++)
         step_x(1'b1, "pu_hold", pk(1'b0, 2'b00, 4'b0000, md, mil));
      step_x(1'b1, "pu_on", pk(1'b1, 2'b00, 4'b0000, md, mil));
      power_on = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk(mon_e.tag, {7'd0, power, state, moving_state, mode, mileage}, {7'd0, mon_e.v});
      end
   end

   initial begin : sat_chk
      logic [15:0] prev;
      int          n;
      prev     = 16'd0;
      n        = 0;
      sat_done = 1'b0;
      wait (s_rst === 1'b1);
      while (s_mileage !== 16'hFFFF && n < 70000) begin
         prev = s_mileage;
         @(posedge clk);
         #1;
         n++;
      end
      chk("sat_reach", {16'd0, s_mileage}, 32'h0000FFFF);
      chk("sat_prev",  {16'd0, prev},      32'h0000FFFE);
      repeat (4) @(posedge clk);
      #1;
      chk("sat_hold",  {16'd0, s_mileage}, 32'h0000FFFF);
      sat_done = 1'b1;
   end

   initial begin
      rst = 1'b0;      s_rst = 1'b0;
      tick_ms = 1'b0;  power_on = 1'b0; power_off = 1'b0;
      mode_sel = 2'b00;
      man_state = 2'b00;  man_moving = 4'b0000; man_power = 1'b1;
      semi_state = 2'b00; semi_moving = 4'b0000;
      auto_state = 2'b00; auto_moving = 4'b0000;
      #12;
      chk_reset("reset");
      @(negedge clk);
      rst = 1'b1; s_rst = 1'b1;

      // Aborted power-up
      power_on = 1'b1;
      step_x(1'b0, "arm_entry", pk(1'b0, 2'b00, 4'b0000, 2'b00, 16'd0));
      for (int i = 0; i < 3; i++)
         step_x(1'b1, "arm_tick", pk(1'b0, 2'b00, 4'b0000, 2'b00, 16'd0));
      power_on = 1'b0;
      step_x(1'b0, "arm_abort", pk(1'b0, 2'b00, 4'b0000, 2'b00, 16'd0));
      power_up(2'b00, 16'd0);

      // Manual drive and mileage
      man_state = 2'b10; man_moving = 4'b0001;
      step_x(1'b0, "man_move", pk(1'b1, 2'b10, 4'b0001, 2'b00, 16'd0));
      for (int i = 1; i <= 9; i++)
         step_x(1'b1, "mile", pk(1'b1, 2'b10, 4'b0001, 2'b00, 16'(i / 3)));

      // Mode switch deferred until NSTART
      mode_sel = 2'b10;
      step_x(1'b0, "defer_moving", pk(1'b1, 2'b10, 4'b0001, 2'b00, 16'd3));
      man_state = 2'b00; man_moving = 4'b0000;
      step_x(1'b0, "man_stop", pk(1'b1, 2'b00, 4'b0000, 2'b00, 16'd3));
      auto_state = 2'b01; auto_moving = 4'b0001;
      step_x(1'b0, "mode_grant", pk(1'b1, 2'b00, 4'b0000, 2'b10, 16'd3));
      step_x(1'b0, "auto_drive", pk(1'b1, 2'b01, 4'b0001, 2'b10, 16'd3));
      man_power = 1'b0;
      step_x(1'b0, "stall_ignored", pk(1'b1, 2'b01, 4'b0001, 2'b10, 16'd3));
      man_power = 1'b1; mode_sel = 2'b01; semi_state = 2'b10; semi_moving = 4'b0010;
      step_x(1'b0, "defer_start", pk(1'b1, 2'b01, 4'b0001, 2'b10, 16'd3));
      power_off = 1'b1;
      step_x(1'b0, "power_off", pk(1'b0, 2'b00, 4'b0000, 2'b10, 16'd3));
      power_off = 1'b0; mode_sel = 2'b11; auto_state = 2'b00; auto_moving = 4'b0000;
      power_up(2'b10, 16'd3);
      step_x(1'b0, "mode_11", pk(1'b1, 2'b00, 4'b0000, 2'b00, 16'd3));
      man_state = 2'b01;
      step_x(1'b0, "man_start", pk(1'b1, 2'b01, 4'b0000, 2'b00, 16'd3));
      man_power = 1'b0;
      step_x(1'b0, "man_stall", pk(1'b0, 2'b00, 4'b0000, 2'b00, 16'd3));
      man_power = 1'b1; man_state = 2'b00;

      // power_off wins over power_on
      power_on = 1'b1; power_off = 1'b1;
      for (int i = 0; i < 6; i++)
         step_x(1'b1, "both_off", pk(1'b0, 2'b00, 4'b0000, 2'b00, 16'd3));
      power_off = 1'b0;
      power_up(2'b00, 16'd3);

      // Idle timeout, restarted by a START excursion
      for (int i = 0; i < 5; i++)
         step_x(1'b1, "idle_cnt", pk(1'b1, 2'b00, 4'b0000, 2'b00, 16'd3));
      man_state = 2'b01;
      step_x(1'b0, "idle_start", pk(1'b1, 2'b01, 4'b0000, 2'b00, 16'd3));
      man_state = 2'b00;
      step_x(1'b0, "idle_back", pk(1'b1, 2'b00, 4'b0000, 2'b00, 16'd3));
      for (int i = 0; i < 7; i++)
         step_x(1'b1, "idle_cnt2", pk(1'b1, 2'b00, 4'b0000, 2'b00, 16'd3));
      step_x(1'b1, "idle_timeout", pk(1'b0, 2'b00, 4'b0000, 2'b00, 16'd3));

      // Asynchronous reset while moving under auto
      power_up(2'b00, 16'd3);
      mode_sel = 2'b10; man_state = 2'b10; man_moving = 4'b0100;
      auto_state = 2'b10; auto_moving = 4'b0100;
      step_x(1'b0, "rst_move", pk(1'b1, 2'b10, 4'b0100, 2'b10, 16'd3));
      for (int i = 1; i <= 4; i++)
         step_x(1'b1, "rst_mile", pk(1'b1, 2'b10, 4'b0100, 2'b10, 16'(3 + i / 3)));
      power_on = 1'b1; mode_sel = 2'b00;
      #2;
      rst = 1'b0;
      #1;
      chk_reset("rst_mid");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      power_up(2'b00, 16'd0);

      wait (sat_done === 1'b1);
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0)
         chk("queue_drain", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
